// File: rtl/dma_ch_buf.sv
// dma_ch_buf: per-channel circular byte store that compacts byte-enabled source words
// and hands out 1..BE_WD LSB-aligned bytes per pop to the destination controller.
module dma_ch_buf #(
    parameter int DATA_WD = 32,
    parameter int BE_WD   = DATA_WD/8,
    parameter int DEPTH   = 32,
    parameter int CNT_WD  = $clog2(DEPTH)+1,
    parameter int RB_WD   = $clog2(BE_WD)+1
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               clr_i,
    input  logic               buf_wvalid_i,
    input  logic [BE_WD-1:0]   buf_wbe_i,
    input  logic [DATA_WD-1:0] buf_wdata_i,
    output logic               buf_wready_o,
    input  logic [RB_WD-1:0]   buf_rbytes_i,
    input  logic               buf_rready_i,
    output logic               buf_rvalid_o,
    output logic [DATA_WD-1:0] buf_rdata_o,
    output logic [CNT_WD-1:0]  buf_level_o,
    output logic               buf_empty_o,
    output logic               buf_err_o
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]         mem [DEPTH];
    logic [PW-1:0]      wptr, rptr;
    logic [CNT_WD-1:0]  level, level_nxt;
    logic               err;
    logic [RB_WD-1:0]   wn, woff;
    logic [BE_WD:0]     wmask;
    logic [DATA_WD-1:0] wsh;
    logic               be_ok, wfire, rfire, rb_bad;

    // Byte count, first enabled lane and contiguity of the write enables
    always_comb begin
        wn   = '0;
        woff = '0;
        for (int k = 0; k < BE_WD; k++) wn = wn + RB_WD'(buf_wbe_i[k]);
        for (int k = BE_WD-1; k >= 0; k--) if (buf_wbe_i[k]) woff = RB_WD'(k);
        wmask = ((BE_WD+1)'(1) << wn) - (BE_WD+1)'(1);
        be_ok = (|buf_wbe_i) && ({1'b0, buf_wbe_i >> woff} == wmask);
        wsh   = buf_wdata_i >> {woff, 3'b000};
    end

    assign buf_wready_o = level <= CNT_WD'(DEPTH - BE_WD);
    assign rb_bad       = buf_rbytes_i > RB_WD'(BE_WD);
    assign buf_rvalid_o = (|buf_rbytes_i) && !rb_bad && (level >= CNT_WD'(buf_rbytes_i));
    assign wfire        = buf_wvalid_i && buf_wready_o;
    assign rfire        = buf_rvalid_o && buf_rready_i;
    assign level_nxt    = level + ((wfire && be_ok) ? CNT_WD'(wn) : '0)
                                - (rfire ? CNT_WD'(buf_rbytes_i) : '0);
    assign buf_level_o  = level;
    assign buf_empty_o  = level == '0;
    assign buf_err_o    = err;

    always_comb begin
        buf_rdata_o = '0;
        for (int k = 0; k < BE_WD; k++)
            if (RB_WD'(k) < buf_rbytes_i) buf_rdata_o[8*k +: 8] = mem[rptr + PW'(k)];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            err   <= 1'b0;
        end else if (clr_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            err   <= 1'b0;
        end else begin
            if (wfire && be_ok) wptr <= wptr + PW'(wn);
            if (rfire) rptr <= rptr + PW'(buf_rbytes_i);
            level <= level_nxt;
            if ((wfire && !be_ok) || (buf_rready_i && rb_bad)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (!clr_i && wfire && be_ok) begin
            for (int k = 0; k < BE_WD; k++)
                if (RB_WD'(k) < wn) mem[wptr + PW'(k)] <= wsh[8*k +: 8];
        end
    end
endmodule
